// File: rtl/serial_dac_stream_driver.sv
// Serial DAC write engine: shifts NUM_CH words MSB-first on a shared SCLK/LD/CLR,
// with a queued clear command and an automatic clear after reset.
module serial_dac_stream_driver #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 1,
    parameter int CLK_DIV = 2,
    parameter int LD_GAP  = 2,
    parameter int LD_W    = 2,
    parameter int CLR_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     done,
    output logic                     dac_sclk,
    output logic [NUM_CH-1:0]        dac_sdi,
    output logic                     dac_ld_n,
    output logic                     dac_clr_n
);

    localparam int M1   = (CLK_DIV > LD_GAP) ? CLK_DIV : LD_GAP;
    localparam int M2   = (LD_W > CLR_W) ? LD_W : CLR_W;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = $clog2(DATA_W);

    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(LD_GAP - 1);
    localparam logic [CW-1:0] LD_END  = CW'(LD_W - 1);
    localparam logic [CW-1:0] CLR_END = CW'(CLR_W - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_LOAD
    } state_t;

    state_t                           state;
    logic [CW-1:0]                    cnt;
    logic [BW-1:0]                    bitn;
    logic [NUM_CH-1:0][DATA_W-1:0]    sh;
    logic                             ready_q;
    logic                             pend;

    // A clear wins over a same-cycle word, so mask ready while one is due.
    assign in_ready = ready_q & ~clr_req & ~pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_CLR;
            cnt       <= '0;
            bitn      <= '0;
            sh        <= '0;
            ready_q   <= 1'b0;
            pend      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            dac_sclk  <= 1'b1;
            dac_sdi   <= '0;
            dac_ld_n  <= 1'b1;
            dac_clr_n <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && clr_req) begin
                pend <= 1'b1;
            end
            unique case (state)
                S_CLR: begin
                    if (cnt == CLR_END) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        dac_clr_n <= 1'b1;
                        ready_q   <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (pend || clr_req) begin
                        state     <= S_CLR;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        dac_clr_n <= 1'b0;
                        ready_q   <= 1'b0;
                        busy      <= 1'b1;
                    end else if (in_valid) begin
                        state    <= S_SHIFT;
                        cnt      <= '0;
                        bitn     <= BIT_TOP;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                        dac_sclk <= 1'b0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            dac_sdi[c] <= in_data[c*DATA_W + DATA_W - 1];
                            sh[c]      <= in_data[c*DATA_W +: DATA_W] << 1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt != DIV_END) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else if (bitn == '0) begin
                            state <= S_GAP;
                        end else begin
                            // Next bit is presented on the falling edge only.
                            bitn     <= bitn - BW'(1);
                            dac_sclk <= 1'b0;
                            for (int c = 0; c < NUM_CH; c++) begin
                                dac_sdi[c] <= sh[c][DATA_W-1];
                                sh[c]      <= sh[c] << 1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_END) begin
                        state    <= S_LOAD;
                        cnt      <= '0;
                        dac_ld_n <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOAD: begin
                    if (cnt == LD_END) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        dac_ld_n <= 1'b1;
                        done     <= 1'b1;
                        ready_q  <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_dac_stream_driver.sv
// Bench for serial_dac_stream_driver: directed vectors, corner sequences and
// randomized traffic against a cycle-index reference model.
module tb_serial_dac_stream_driver;

    localparam int D    = 12;
    localparam int NC   = 2;
    localparam int C    = 2;
    localparam int G    = 2;
    localparam int W    = 2;
    localparam int CLRW = 2;
    localparam int X    = 2*C*D + G + W;

    localparam int M_IDLE = 0;
    localparam int M_CLR  = 1;
    localparam int M_XFER = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NC*D-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            clr_req = 1'b0;
    logic            in_ready, busy, done;
    logic            dac_sclk, dac_ld_n, dac_clr_n;
    logic [NC-1:0]   dac_sdi;

    always #5 clk = ~clk;

    serial_dac_stream_driver #(
        .DATA_W(D), .NUM_CH(NC), .CLK_DIV(C),
        .LD_GAP(G), .LD_W(W), .CLR_W(CLRW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clr_req(clr_req), .busy(busy), .done(done),
        .dac_sclk(dac_sclk), .dac_sdi(dac_sdi),
        .dac_ld_n(dac_ld_n), .dac_clr_n(dac_clr_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // Reference model: mode plus cycle index within the mode.
    int         mmode, mk;
    bit         pend, jd, chk_en = 0;
    logic [D-1:0] w0, w1;
    logic [1:0] hold;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmode = M_CLR; mk = 1; pend = 0; jd = 0; hold = '0;
        end else begin
            case (mmode)
                M_IDLE: begin
                    jd = 0;
                    if (pend || clr_req) begin
                        mmode = M_CLR; mk = 1; pend = 0;
                    end else if (in_valid) begin
                        mmode = M_XFER; mk = 1;
                        w0 = in_data[D-1:0];
                        w1 = in_data[2*D-1:D];
                    end
                end
                M_CLR: begin
                    if (clr_req) pend = 1;
                    if (mk == CLRW) mmode = M_IDLE;
                    else mk++;
                end
                default: begin
                    if (clr_req) pend = 1;
                    if (mk == X) begin
                        mmode = M_IDLE; jd = 1; hold = {w1[0], w0[0]};
                    end else mk++;
                end
            endcase
        end
    end

    logic e_sclk, e_ld, e_clr, e_busy, e_rdy, e_done;
    logic [1:0] e_sdi;
    int ph;

    always @(negedge clk) begin
        if (reset && chk_en) begin
            e_sclk = 1; e_ld = 1; e_clr = 1; e_busy = 1;
            e_rdy = 0; e_done = 0; e_sdi = hold;
            if (mmode == M_IDLE) begin
                e_busy = 0;
                e_rdy  = !clr_req && !pend;
                e_done = jd;
            end else if (mmode == M_CLR) begin
                e_clr = 0;
            end else if (mk <= 2*C*D) begin
                ph       = (mk - 1) / C;
                e_sclk   = ph[0];
                e_sdi[0] = w0[D-1-ph/2];
                e_sdi[1] = w1[D-1-ph/2];
            end else begin
                e_sdi = {w1[0], w0[0]};
                if (mk > 2*C*D + G) e_ld = 0;
            end
            chk("m_sclk", dac_sclk, e_sclk);
            chk("m_sdi", dac_sdi, e_sdi);
            chk("m_ld_n", dac_ld_n, e_ld);
            chk("m_clr_n", dac_clr_n, e_clr);
            chk("m_busy", busy, e_busy);
            chk("m_ready", in_ready, e_rdy);
            chk("m_done", done, e_done);
        end
    end

    logic [D-1:0] cap0, cap1;
    int nrise = 0;
    int nld = 0;

    always @(posedge dac_sclk) if (reset) begin
        cap0 = {cap0[D-2:0], dac_sdi[0]};
        cap1 = {cap1[D-2:0], dac_sdi[1]};
        nrise++;
    end

    always @(negedge dac_ld_n) if (reset) nld++;

    task automatic chk_rst(input string p);
        chk({p, "_sclk"}, dac_sclk, 1);
        chk({p, "_sdi"}, dac_sdi, 0);
        chk({p, "_ld_n"}, dac_ld_n, 1);
        chk({p, "_clr_n"}, dac_clr_n, 0);
        chk({p, "_ready"}, in_ready, 0);
        chk({p, "_busy"}, busy, 1);
        chk({p, "_done"}, done, 0);
    endtask

    task automatic send(input logic [D-1:0] a0, input logic [D-1:0] a1, output int hs);
        cap0 = '0; cap1 = '0; nrise = 0;
        @(posedge clk); #1;
        in_data = {a1, a0};
        in_valid = 1;
        hs = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin hs = cyc; break; end
        end
        if (hs < 0) timeout("accept");
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_done(output int dc, output int ldn, output int ldf);
        dc = -1; ldn = 0; ldf = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!dac_ld_n) begin
                ldn++;
                if (ldf < 0) ldf = cyc;
            end
            if (done) begin dc = cyc; break; end
        end
        if (dc < 0) timeout("done");
    endtask

    typedef struct {
        logic [D-1:0] d0, d1;
        logic [D-1:0] e0, e1;
        int lat, ldoff;
    } vec_t;

    vec_t tv[4];

    initial begin
        int hs, dc, ldn, ldf, n, acc, nld0;
        tv[0] = '{12'hA5C, 12'h000, 12'hA5C, 12'h000, 53, 51};
        tv[1] = '{12'hF00, 12'h0FF, 12'hF00, 12'h0FF, 53, 51};
        tv[2] = '{12'hFFF, 12'h001, 12'hFFF, 12'h001, 53, 51};
        tv[3] = '{12'h800, 12'h7FF, 12'h800, 12'h7FF, 53, 51};

        repeat (3) @(posedge clk);
        #1 chk_rst("rst");
        chk_en = 1;
        @(posedge clk); #1 reset = 1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!dac_clr_n) n++;
        end
        chk("por_clr_cycles", n, CLRW);
        chk("por_ready", in_ready, 1);

        for (int v = 0; v < 4; v++) begin
            send(tv[v].d0, tv[v].d1, hs);
            wait_done(dc, ldn, ldf);
            chk($sformatf("v%0d_ch0", v), cap0, tv[v].e0);
            chk($sformatf("v%0d_ch1", v), cap1, tv[v].e1);
            chk($sformatf("v%0d_rises", v), nrise, D);
            chk($sformatf("v%0d_lat", v), dc - hs, tv[v].lat);
            chk($sformatf("v%0d_ld_w", v), ldn, W);
            chk($sformatf("v%0d_ld_off", v), ldf - hs, tv[v].ldoff);
        end

        // clear request during SHIFT with the next word already waiting
        nld0 = nld;
        @(posedge clk); #1;
        in_data = {12'h3C3, 12'h5A5};
        in_valid = 1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin hs = cyc; break; end
        end
        if (hs < 0) timeout("mid_accept");
        repeat (10) @(posedge clk);
        #1 clr_req = 1;
        @(posedge clk); #1 clr_req = 0;
        wait_done(dc, ldn, ldf);
        chk("mid_ld_pulses", nld - nld0, 1);
        n = 0; acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!dac_clr_n) n++;
            if (in_ready) begin acc = cyc; break; end
        end
        chk("mid_clr_cycles", n, CLRW);
        chk("mid_accept_gap", acc - dc, CLRW + 1);
        @(posedge clk); #1 in_valid = 0;
        wait_done(dc, ldn, ldf);

        // clear and word together in IDLE
        @(posedge clk); #1;
        clr_req = 1;
        in_valid = 1;
        in_data = {12'h123, 12'h456};
        n = 0;
        @(negedge clk);
        if (!in_ready) n++;
        @(posedge clk); #1 clr_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("both_ready_low", n, CLRW + 1);
        @(posedge clk); #1 in_valid = 0;
        wait_done(dc, ldn, ldf);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            clr_req  = ($urandom_range(0, 39) == 0);
            in_data  = NC*D'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 0; clr_req = 0;
        repeat (80) @(posedge clk);

        // reset asserted at SHIFT bit 6
        send(12'hABC, 12'h321, hs);
        for (int i = 0; i < 100 && cyc < hs + 21; i++) @(negedge clk);
        nld0 = nld;
        #2 reset = 0;
        #1 chk_rst("abort");
        repeat (3) @(posedge clk);
        #1 reset = 1;
        repeat (60) @(posedge clk);
        chk("abort_no_ld", nld - nld0, 0);
        send(12'h001, 12'h001, hs);
        wait_done(dc, ldn, ldf);
        chk("post_ch0", cap0, 12'h001);
        chk("post_ch1", cap1, 12'h001);
        chk("post_lat", dc - hs, 53);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
